spi_flash_arbiter: RTL and testbench

- Shares the board's single SPI flash between two requesters: port 0 is instruction fetch and port 1 is data/boot loader.
- Performs 32-bit word reads using the standard READ command (0x03), a 24-bit address and SPI mode 0.
- Sits between the tinyQV core complex and the flash_spi_* pins in the FPGA top level, running on the 64 MHz core clock.
- Requester 1 (data) takes fixed priority on simultaneous requests, except when port 0 has been starved.

---
 rtl/flash_pkg.sv | 21 ++
 rtl/spi_flash_shifter.sv | 104 ++++++++++
 rtl/spi_flash_arbiter.sv | 137 +++++++++++++
 tb/tb_spi_flash_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared constants and types for the SPI flash arbiter
package flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         ADDR_W   = 24;
  localparam int         WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  typedef logic port_id_t;

  // Flash returns byte 0 first; the word is presented little-endian.
  function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_flash_shifter.sv
// rtl/spi_flash_shifter.sv - 64-bit mode-0 SPI shift engine with SCK divider
module spi_flash_shifter
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              miso_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rx_word_o
);

  logic              active_q, active_d;
  logic              phase_q, phase_d;     // 0: sck-low phase, 1: sck-high phase
  logic [3:0]        div_cnt_q, div_cnt_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [WORD_W-1:0] rx_q, rx_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              div_end;
  logic              sample;

  assign div_end = (div_cnt_q == 4'(CLK_DIV - 1));
  // miso is captured on the first cycle sck is high.
  assign sample  = active_q && phase_q && (div_cnt_q == 4'd0);
  // Includes the bit sampled this cycle so the final bit is visible with done_o.
  assign rx_word_o = sample ? {rx_q[WORD_W-2:0], miso_i} : rx_q;
  assign done_o    = active_q && phase_q && div_end && (bit_cnt_q == 6'd63);
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;

  // Next-state: divider, phase toggling, transmit and receive shifting.
  always_comb begin
    active_d  = active_q;
    phase_d   = phase_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_word_o;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    if (start_i) begin
      active_d  = 1'b1;
      phase_d   = 1'b0;
      div_cnt_d = 4'd0;
      bit_cnt_d = 6'd0;
      tx_d      = {word_i[WORD_W-2:0], 1'b0};
      mosi_d    = word_i[WORD_W-1];
      sck_d     = 1'b0;
    end else if (active_q) begin
      if (!div_end) begin
        div_cnt_d = div_cnt_q + 4'd1;
      end else begin
        div_cnt_d = 4'd0;
        if (!phase_q) begin
          phase_d = 1'b1;
          sck_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          sck_d   = 1'b0;
          if (bit_cnt_q == 6'd63) begin
            active_d = 1'b0;
            mosi_d   = 1'b0;
          end else begin
            // tx_q has been zero-filled by now during the data bits.
            bit_cnt_d = bit_cnt_q + 6'd1;
            mosi_d    = tx_q[WORD_W-1];
            tx_d      = {tx_q[WORD_W-2:0], 1'b0};
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      phase_q   <= 1'b0;
      div_cnt_q <= 4'd0;
      bit_cnt_q <= 6'd0;
      tx_q      <= '0;
      rx_q      <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      phase_q   <= phase_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-port SPI flash word-read arbiter
module spi_flash_arbiter
  import flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int CS_HIGH    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [WORD_W-1:0] rdata,
  output logic              busy,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_wp_n,
  output logic              spi_hold_n
);

  state_e            state_q, state_d;
  port_id_t          port_q, port_d;
  port_id_t          grant;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              start;
  logic [WORD_W-1:0] tx_word;
  logic              sh_done;
  logic [WORD_W-1:0] sh_rx;

  // Port 1 wins unless port 0 is waiting and has already lost STARVE_MAX times in a row.
  assign grant   = (req1 && (!req0 || (starve_cnt_q < 8'(STARVE_MAX)))) ? 1'b1 : 1'b0;
  assign tx_word = {CMD_READ, (grant ? addr1 : addr0)};

  spi_flash_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .word_i    (tx_word),
    .miso_i    (spi_miso),
    .sck_o     (spi_sck),
    .mosi_o    (spi_mosi),
    .done_o    (sh_done),
    .rx_word_o (sh_rx)
  );

  // Next-state: arbitration in IDLE, wait for shifter, then hold cs_n high for the gap.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    starve_cnt_d = starve_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    busy_d       = busy_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    start        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          start        = 1'b1;
          port_d       = grant;
          busy_d       = 1'b1;
          cs_n_d       = 1'b0;
          state_d      = SHIFT;
          starve_cnt_d = (grant && req0) ? starve_cnt_q + 8'd1 : 8'd0;
        end
      end
      SHIFT: begin
        if (sh_done) begin
          cs_n_d    = 1'b1;
          rdata_d   = byte_swap(sh_rx);
          ack0_d    = !port_q;
          ack1_d    = port_q;
          gap_cnt_d = 4'd0;
          state_d   = GAP;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        if (gap_cnt_q == 4'(CS_HIGH - 1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      starve_cnt_q <= 8'd0;
      gap_cnt_q    <= 4'd0;
      cs_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      starve_cnt_q <= starve_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cs_n_q       <= cs_n_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_wp_n   = 1'b1;
  assign spi_hold_n = 1'b1;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic miso = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic        d_req0 = 0, d_req1 = 0, f_req0 = 0, f_req1 = 0;
  logic [23:0] d_addr0 = 0, d_addr1 = 0, f_addr0 = 0, f_addr1 = 0;
  logic        d_ack0, d_ack1, d_busy, d_cs_n, d_sck, d_mosi, d_wp_n, d_hold_n;
  logic        f_ack0, f_ack1, f_busy, f_cs_n, f_sck, f_mosi, f_wp_n, f_hold_n;
  logic [31:0] d_rdata, f_rdata;

  logic        m_ack0, m_ack1, m_busy, m_cs_n, m_sck, m_mosi;
  logic [31:0] m_rdata;
  assign m_ack0  = sel ? f_ack0  : d_ack0;
  assign m_ack1  = sel ? f_ack1  : d_ack1;
  assign m_busy  = sel ? f_busy  : d_busy;
  assign m_cs_n  = sel ? f_cs_n  : d_cs_n;
  assign m_sck   = sel ? f_sck   : d_sck;
  assign m_mosi  = sel ? f_mosi  : d_mosi;
  assign m_rdata = sel ? f_rdata : d_rdata;

  spi_flash_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(d_req0), .addr0(d_addr0), .ack0(d_ack0),
    .req1(d_req1), .addr1(d_addr1), .ack1(d_ack1),
    .rdata(d_rdata), .busy(d_busy),
    .spi_cs_n(d_cs_n), .spi_sck(d_sck), .spi_mosi(d_mosi), .spi_miso(miso),
    .spi_wp_n(d_wp_n), .spi_hold_n(d_hold_n)
  );

  spi_flash_arbiter #(.CLK_DIV(1), .CS_HIGH(2), .STARVE_MAX(3)) dut_f (
    .clk(clk), .rst_n(rst_n),
    .req0(f_req0), .addr0(f_addr0), .ack0(f_ack0),
    .req1(f_req1), .addr1(f_addr1), .ack1(f_ack1),
    .rdata(f_rdata), .busy(f_busy),
    .spi_cs_n(f_cs_n), .spi_sck(f_sck), .spi_mosi(f_mosi), .spi_miso(miso),
    .spi_wp_n(f_wp_n), .spi_hold_n(f_hold_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural READ-only flash on the selected bus.
  logic [7:0]  mem [0:1023];
  int          fbit = 0;
  logic [31:0] fcmd = 0;
  logic [31:0] last_cmd = 0;
  logic        fprev_sck = 0;
  int          mosi_bad = 0;
  always @(m_cs_n or m_sck) begin
    if (m_cs_n) begin
      fbit = 0;
      miso = 1'b0;
    end else if (m_sck && !fprev_sck) begin
      if (fbit < 32) fcmd = {fcmd[30:0], m_mosi};
      else if (m_mosi !== 1'b0) mosi_bad++;
      fbit++;
      if (fbit == 32) last_cmd = fcmd;
    end else if (!m_sck && fprev_sck) begin
      if (fbit >= 32 && fbit < 64)
        miso = mem[(int'(fcmd[23:0]) + (fbit - 32) / 8) & 1023][7 - ((fbit - 32) % 8)];
    end
    fprev_sck = m_sck;
  end

  // Sticky observations checked at the end.
  int ack_overlap = 0, pin_bad = 0, d_ack1_cnt = 0;
  int last_rise = -1, sck_min = 99, sck_max = 0;
  int high_run = 0, last_gap = 0, seen_txn = 0;
  logic mon_prev_sck = 0, mon_prev_cs = 1;
  always @(negedge clk) begin
    if ((d_ack0 && d_ack1) || (f_ack0 && f_ack1)) ack_overlap++;
    if (d_wp_n !== 1'b1 || d_hold_n !== 1'b1 || f_wp_n !== 1'b1 || f_hold_n !== 1'b1) pin_bad++;
    if (d_ack1) d_ack1_cnt++;
    if (sel) begin
      if (!m_cs_n && m_sck && !mon_prev_sck) begin
        if (last_rise >= 0) begin
          if (cyc - last_rise < sck_min) sck_min = cyc - last_rise;
          if (cyc - last_rise > sck_max) sck_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (m_cs_n) begin
        last_rise = -1;
        high_run++;
      end else begin
        if (mon_prev_cs && seen_txn != 0) last_gap = high_run;
        high_run = 0;
        seen_txn = 1;
      end
    end
    mon_prev_sck = m_sck;
    mon_prev_cs  = m_cs_n;
  end

  function automatic logic [31:0] exp_word(input int a);
    return {mem[(a + 3) & 1023], mem[(a + 2) & 1023], mem[(a + 1) & 1023], mem[a & 1023]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int port, output int t, output logic [31:0] rd);
    bit found = 0;
    port = -1; t = 0; rd = 'x;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (m_ack0 || m_ack1) begin
        found = 1; port = m_ack1 ? 1 : 0; t = cyc; rd = m_rdata;
      end
    end
  endtask

  task automatic wait_busy(input logic level, output int t);
    bit found = 0;
    t = -1;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (m_busy === level) begin found = 1; t = cyc; end
    end
  endtask

  initial begin
    int port, t1, t2, tb, a, b, starve_m, exp_port;
    logic [31:0] rd;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(d_cs_n), 1);
    check("rst_sck", 32'(d_sck), 0);
    check("rst_mosi", 32'(d_mosi), 0);
    check("rst_acks", {30'd0, d_ack1, d_ack0}, 0);
    check("rst_rdata", d_rdata, 0);
    check("rst_busy", 32'(d_busy), 0);
    check("rst_f_cs_n", 32'(f_cs_n), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read
    d_req0 = 1; d_addr0 = 24'h000100;
    wait_busy(1, tb);
    wait_ack(port, t2, rd);
    d_req0 = 0;
    check("single_port", port, 0);
    check("single_latency", t2 - tb + 1, 257);
    check("single_rdata", rd, 32'h44332211);
    check("single_mosi", last_cmd, 32'h03000100);
    check("single_no_ack1", d_ack1_cnt, 0);
    wait_busy(0, tb);

    // Unaligned read
    d_req0 = 1; d_addr0 = 24'h000003;
    wait_ack(port, t2, rd);
    d_req0 = 0;
    check("unal_port", port, 0);
    check("unal_rdata", rd, exp_word(3));
    wait_busy(0, tb);

    // Simultaneous requests
    d_req0 = 1; d_addr0 = 24'h10; d_req1 = 1; d_addr1 = 24'h20;
    wait_ack(port, t1, rd);
    d_req1 = 0;
    check("simul_first_port", port, 1);
    check("simul_rdata1", rd, exp_word(32'h20));
    wait_ack(port, t2, rd);
    d_req0 = 0;
    check("simul_second_port", port, 0);
    check("simul_spacing", t2 - t1, 261);
    check("simul_rdata0", rd, exp_word(32'h10));
    wait_busy(0, tb);

    // Starvation: port 1 held, port 0 waiting
    starve_m = 0;
    a = $urandom_range(0, 1000); b = $urandom_range(0, 1000);
    d_req0 = 1; d_addr0 = 24'(a); d_req1 = 1; d_addr1 = 24'(b);
    for (int g = 0; g < 4; g++) begin
      exp_port = (starve_m < 3) ? 1 : 0;
      starve_m = (exp_port == 1) ? starve_m + 1 : 0;
      wait_ack(port, t1, rd);
      check($sformatf("starve_grant%0d", g), port, exp_port);
      check($sformatf("starve_rdata%0d", g), rd, exp_word(exp_port == 1 ? b : a));
      if (exp_port == 1) begin
        b = $urandom_range(0, 1000); d_addr1 = 24'(b);
      end else begin
        check("starve_cnt_cleared", 32'(dut.starve_cnt_q), 0);
        d_req0 = 0; d_req1 = 0;
      end
    end
    wait_busy(0, tb);

    // Reset in the middle of a read; request stays high
    a = $urandom_range(0, 1000);
    t1 = d_ack1_cnt;
    d_req0 = 1; d_addr0 = 24'(a);
    wait_busy(1, tb);
    repeat (98) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cs_n", 32'(d_cs_n), 1);
    check("mid_rst_sck", 32'(d_sck), 0);
    check("mid_rst_busy", 32'(d_busy), 0);
    check("mid_rst_no_ack", {30'd0, d_ack1, d_ack0}, 0);
    rst_n = 1'b1;
    wait_ack(port, t2, rd);
    d_req0 = 0;
    check("mid_rst_port", port, 0);
    check("mid_rst_rdata", rd, exp_word(a));
    check("mid_rst_cmd", last_cmd, {8'h03, 24'(a)});
    check("mid_rst_no_ack1", d_ack1_cnt, t1);
    wait_busy(0, tb);

    // Fast instance: CLK_DIV=1, CS_HIGH=2, back-to-back reads on port 0
    sel = 1'b1;
    @(negedge clk);
    a = $urandom_range(0, 1000); b = $urandom_range(0, 1000);
    f_req0 = 1; f_addr0 = 24'(a);
    wait_busy(1, tb);
    wait_ack(port, t1, rd);
    f_addr0 = 24'(b);
    check("fast_port1", port, 0);
    check("fast_latency", t1 - tb + 1, 129);
    check("fast_rdata1", rd, exp_word(a));
    wait_ack(port, t2, rd);
    f_req0 = 0;
    check("fast_port2", port, 0);
    check("fast_spacing", t2 - t1, 131);
    check("fast_rdata2", rd, exp_word(b));
    check("fast_cmd", last_cmd, {8'h03, 24'(b)});
    check("fast_sck_min", sck_min, 2);
    check("fast_sck_max", sck_max, 2);
    check("fast_cs_gap_ge2", 32'(last_gap >= 2), 1);
    wait_busy(0, tb);
    sel = 1'b0;

    // Whole-run observations
    check("acks_exclusive", ack_overlap, 0);
    check("wp_hold_high", pin_bad, 0);
    check("mosi_zero_in_data", mosi_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
